vga_timing_gen: RTL and testbench

- Raster timing generator feeding every flag stage.
- Produces pix_x/pix_y coordinates, active-low syncs, a display-enable and a frame counter for 640x480@60 Hz from a 25.175 MHz pixel clock.
- Flag stages map (pix_x, pix_y, frame) to 6-bit RRGGBB colour.
- The top level gates that colour with display_on and drives hsync/vsync to the pins.

---
 rtl/vga_timing_gen_pkg.sv | 52 +++++
 rtl/vga_timing_gen_if.sv | 30 +++
 rtl/vga_timing_gen_wrap_counter.sv | 31 +++
 rtl/vga_timing_gen.sv | 148 ++++++++++++++
 tb/tb_vga_timing_gen.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/vga_timing_gen_pkg.sv
// vga_pkg: shared timing constants, coordinate/colour types and named colours
// for the raster timing generator and the flag stages that consume pix_x/pix_y.
//   DEF_*           default 640x480@60 timing (25.175 MHz pixel clock)
//   coord_t         10-bit raster coordinate
//   rgb_t           6-bit RRGGBB colour
//   COL_*           named colours shared with the flag stages
//   in_window()     half-open range test lo <= v < hi
package vga_pkg;

  localparam int unsigned COORD_W     = 10;
  localparam int unsigned COORD_LIMIT = 1 << COORD_W;

  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_H_FP     = 16;
  localparam int unsigned DEF_H_SYNC   = 96;
  localparam int unsigned DEF_H_BP     = 48;
  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_V_FP     = 10;
  localparam int unsigned DEF_V_SYNC   = 2;
  localparam int unsigned DEF_V_BP     = 33;
  localparam int unsigned DEF_FRAME_W  = 8;

  localparam int unsigned DEF_H_TOTAL    = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int unsigned DEF_V_TOTAL    = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;
  localparam int unsigned DEF_HS_START   = DEF_H_ACTIVE + DEF_H_FP;
  localparam int unsigned DEF_HS_END     = DEF_HS_START + DEF_H_SYNC;
  localparam int unsigned DEF_VS_START   = DEF_V_ACTIVE + DEF_V_FP;
  localparam int unsigned DEF_VS_END     = DEF_VS_START + DEF_V_SYNC;

  typedef logic [COORD_W-1:0] coord_t;

  typedef struct packed {
    logic [1:0] r;
    logic [1:0] g;
    logic [1:0] b;
  } rgb_t;

  localparam rgb_t COL_BLACK  = 6'b00_00_00;
  localparam rgb_t COL_WHITE  = 6'b11_11_11;
  localparam rgb_t COL_RED    = 6'b11_00_00;
  localparam rgb_t COL_GREEN  = 6'b00_11_00;
  localparam rgb_t COL_BLUE   = 6'b00_00_11;
  localparam rgb_t COL_YELLOW = 6'b11_11_00;
  localparam rgb_t COL_ORANGE = 6'b11_01_00;

  // Zero-extend before comparing so a window ending at COORD_LIMIT still works.
  function automatic logic in_window(input coord_t v, input int unsigned lo,
                                     input int unsigned hi);
    return (32'(v) >= lo) && (32'(v) < hi);
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// vga_timing_gen_if: raster timing bundle from the generator to the flag stages.
//   pix_x/pix_y   current raster position
//   hsync/vsync   active-low syncs
//   display_on    visible-area flag
//   line_start    one-cycle pulse at pix_x==0
//   frame_start   one-cycle pulse at pix_x==0 && pix_y==0
//   frame         frame counter (FRAME_W bits)
// Modports: master (generator drives), slave (consumers read).
interface vga_timing_gen_if #(
  parameter int unsigned FRAME_W = vga_pkg::DEF_FRAME_W
) ();

  logic [vga_pkg::COORD_W-1:0] pix_x;
  logic [vga_pkg::COORD_W-1:0] pix_y;
  logic                        hsync;
  logic                        vsync;
  logic                        display_on;
  logic                        line_start;
  logic                        frame_start;
  logic [FRAME_W-1:0]          frame;

  modport master (
    output pix_x, pix_y, hsync, vsync, display_on, line_start, frame_start, frame
  );

  modport slave (
    input pix_x, pix_y, hsync, vsync, display_on, line_start, frame_start, frame
  );

endinterface

// File: rtl/vga_timing_gen_wrap_counter.sv
// wrap_counter: modulo-(MAX+1) counter with synchronous clear.
//   clk, rst_n  clock, asynchronous active-low reset (count -> 0)
//   inc         advance by one this cycle
//   clr         synchronous clear (wins over inc)
//   count       current value, 0..MAX
//   wrap        high in the cycle where inc moves count from MAX back to 0
module wrap_counter #(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned MAX   = 799
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count,
  output logic             wrap
);

  assign wrap = inc && (count == WIDTH'(MAX));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc) begin
      count <= wrap ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: raster timing generator (default 640x480@60, 25.175 MHz).
//   clk    pixel clock
//   rst_n  asynchronous active-low reset
//   ena    advance enable; all state holds while low
//   vga    timing bundle (master modport): pix_x, pix_y, hsync, vsync,
//          display_on, line_start, frame_start, frame
// Optional macro VGA_TIMING_PIPE_EN: adds one register stage on hsync, vsync
// and display_on so they lag pix_x/pix_y by one cycle (line_start/frame_start
// are not delayed).
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP,
  parameter int unsigned FRAME_W  = DEF_FRAME_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  vga_timing_gen_if.master vga
);

  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HS_START = H_ACTIVE + H_FP;
  localparam int unsigned HS_END   = HS_START + H_SYNC;
  localparam int unsigned VS_START = V_ACTIVE + V_FP;
  localparam int unsigned VS_END   = VS_START + V_SYNC;

  if (H_TOTAL > COORD_LIMIT || V_TOTAL > COORD_LIMIT) begin : g_total_check
    $error("vga_timing_gen: H_TOTAL and V_TOTAL must not exceed 1024");
  end

  coord_t             x;
  coord_t             y;
  coord_t             x_next;
  coord_t             y_next;
  logic               x_wrap;
  logic               y_wrap;
  logic [FRAME_W-1:0] frame_q;
  logic               hs_q;
  logic               vs_q;
  logic               de_q;
  logic               x0_q;
  logic               y0_q;

  wrap_counter #(
    .WIDTH (COORD_W),
    .MAX   (H_TOTAL - 1)
  ) u_x_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (ena),
    .clr   (1'b0),
    .count (x),
    .wrap  (x_wrap)
  );

  wrap_counter #(
    .WIDTH (COORD_W),
    .MAX   (V_TOTAL - 1)
  ) u_y_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (x_wrap),
    .clr   (1'b0),
    .count (y),
    .wrap  (y_wrap)
  );

  // Position the counters will hold after this edge; decoding it into flops
  // keeps the flags aligned with pix_x/pix_y with no combinational glitches.
  always_comb begin
    x_next = x;
    y_next = y;
    if (ena) begin
      x_next = x_wrap ? '0 : x + 1'b1;
    end
    if (x_wrap) begin
      y_next = y_wrap ? '0 : y + 1'b1;
    end
  end

  // y_wrap already implies x_wrap, so it marks the frame boundary on its own.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_q <= '0;
    end else if (y_wrap) begin
      frame_q <= frame_q + 1'b1;
    end
  end

  // Reset values are the decode of position (0,0).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs_q <= 1'b1;
      vs_q <= 1'b1;
      de_q <= 1'b1;
      x0_q <= 1'b1;
      y0_q <= 1'b1;
    end else begin
      hs_q <= !in_window(x_next, HS_START, HS_END);
      vs_q <= !in_window(y_next, VS_START, VS_END);
      de_q <= in_window(x_next, 0, H_ACTIVE) && in_window(y_next, 0, V_ACTIVE);
      x0_q <= (x_next == '0);
      y0_q <= (y_next == '0);
    end
  end

`ifdef VGA_TIMING_PIPE_EN
  logic hs_p;
  logic vs_p;
  logic de_p;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs_p <= 1'b1;
      vs_p <= 1'b1;
      de_p <= 1'b0;
    end else if (ena) begin
      hs_p <= hs_q;
      vs_p <= vs_q;
      de_p <= de_q;
    end
  end

  assign vga.hsync      = hs_p;
  assign vga.vsync      = vs_p;
  assign vga.display_on = de_p;
`else
  assign vga.hsync      = hs_q;
  assign vga.vsync      = vs_q;
  assign vga.display_on = de_q;
`endif

  assign vga.pix_x       = x;
  assign vga.pix_y       = y;
  assign vga.frame       = frame_q;
  assign vga.line_start  = x0_q && ena;
  assign vga.frame_start = x0_q && y0_q && ena;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench: dut_a uses default 640x480 timing for line-level checks,
// dut_b uses a tiny 16x8 raster so frame-level behaviour fits a short run.
module tb_vga_timing_gen;

`ifdef VGA_TIMING_PIPE_EN
  localparam bit PIPE = 1'b1;
`else
  localparam bit PIPE = 1'b0;
`endif

  typedef struct {
    int unsigned cyc;
    bit          sel;
    string       name;
    logic [9:0]  x;
    logic [9:0]  y;
    logic        hs;
    logic        vs;
    logic        de;
    logic        ls;
    logic        fs;
    logic [7:0]  f;
  } exp_t;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        ena_a = 1'b1;
  logic        ena_b = 1'b1;
  int unsigned cyc   = 0;
  int unsigned t_a   = 0;
  int unsigned t_b   = 0;
  int unsigned n_checks = 0;
  int unsigned n_err    = 0;
  bit          done  = 1'b0;
  exp_t        q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  vga_timing_gen_if #(.FRAME_W(8)) vif_a ();
  vga_timing_gen_if #(.FRAME_W(8)) vif_b ();

  vga_timing_gen #(.FRAME_W(8)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .ena   (ena_a),
    .vga   (vif_a)
  );

  vga_timing_gen #(
    .H_ACTIVE (8), .H_FP (2), .H_SYNC (3), .H_BP (3),
    .V_ACTIVE (4), .V_FP (1), .V_SYNC (2), .V_BP (1),
    .FRAME_W  (8)
  ) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .ena   (ena_b),
    .vga   (vif_b)
  );

  // Position and zero-lag flags after t enabled edges since reset.
  function automatic void pos(input bit sel, input int unsigned t,
                              output int unsigned x, output int unsigned y,
                              output int unsigned f, output logic hs,
                              output logic vs, output logic de);
    int unsigned ht  = sel ? 16 : 800;
    int unsigned vt  = sel ? 8  : 525;
    int unsigned ha  = sel ? 8  : 640;
    int unsigned va  = sel ? 4  : 480;
    int unsigned hss = sel ? 10 : 656;
    int unsigned hse = sel ? 13 : 752;
    int unsigned vss = sel ? 5  : 490;
    int unsigned vse = sel ? 7  : 492;
    x  = t % ht;
    y  = (t / ht) % vt;
    f  = (t / (ht * vt)) % 256;
    hs = !(x >= hss && x < hse);
    vs = !(y >= vss && y < vse);
    de = (x < ha) && (y < va);
  endfunction

  function automatic exp_t model(input bit sel, input int unsigned t,
                                 input logic en, input int unsigned c);
    exp_t e;
    int unsigned x, y, f, px, py, pf;
    logic hs, vs, de;
    pos(sel, t, x, y, f, hs, vs, de);
    e.cyc  = c;
    e.sel  = sel;
    e.name = sel ? "model_b" : "model_a";
    e.x    = 10'(x);
    e.y    = 10'(y);
    e.f    = 8'(f);
    e.ls   = (x == 0) && en;
    e.fs   = (x == 0) && (y == 0) && en;
    e.hs   = hs;
    e.vs   = vs;
    e.de   = de;
    if (PIPE) begin
      if (t == 0) begin
        e.hs = 1'b1;
        e.vs = 1'b1;
        e.de = 1'b0;
      end else begin
        pos(sel, t - 1, px, py, pf, hs, vs, de);
        e.hs = hs;
        e.vs = vs;
        e.de = de;
      end
    end
    return e;
  endfunction

  function automatic void dir(input bit sel, input string nm, input int unsigned c,
                              input int unsigned x, input int unsigned y,
                              input logic hs, input logic vs, input logic de,
                              input logic ls, input logic fs, input int unsigned f);
    exp_t e;
    e.cyc = c;  e.sel = sel; e.name = nm;
    e.x = 10'(x); e.y = 10'(y);
    e.hs = hs; e.vs = vs; e.de = de; e.ls = ls; e.fs = fs;
    e.f = 8'(f);
    q.push_back(e);
  endfunction

  task automatic drive(input logic ea, input logic eb);
    ena_a = ea;
    ena_b = eb;
    if (rst_n) begin
      if (ea) t_a++;
      if (eb) t_b++;
    end
    q.push_back(model(1'b0, t_a, ea, cyc + 1));
    q.push_back(model(1'b1, t_b, eb, cyc + 1));
  endtask

  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  task automatic check(input exp_t e);
    logic [9:0] ax, ay;
    logic       ahs, avs, ade, als, afs;
    logic [7:0] af;
    if (e.sel) begin
      ax = vif_b.pix_x; ay = vif_b.pix_y; ahs = vif_b.hsync; avs = vif_b.vsync;
      ade = vif_b.display_on; als = vif_b.line_start; afs = vif_b.frame_start;
      af = vif_b.frame;
    end else begin
      ax = vif_a.pix_x; ay = vif_a.pix_y; ahs = vif_a.hsync; avs = vif_a.vsync;
      ade = vif_a.display_on; als = vif_a.line_start; afs = vif_a.frame_start;
      af = vif_a.frame;
    end
    n_checks++;
    if (ax !== e.x || ay !== e.y || ahs !== e.hs || avs !== e.vs || ade !== e.de ||
        als !== e.ls || afs !== e.fs || af !== e.f) begin
      n_err++;
      $display("FAIL %s cyc=%0d got x=%0d y=%0d hs=%b vs=%b de=%b ls=%b fs=%b fr=%0d want x=%0d y=%0d hs=%b vs=%b de=%b ls=%b fs=%b fr=%0d",
               e.name, e.cyc, ax, ay, ahs, avs, ade, als, afs, af,
               e.x, e.y, e.hs, e.vs, e.de, e.ls, e.fs, e.f);
    end
  endtask

  // Monitor: samples 1 time unit after each falling clock edge, and right after
  // an asynchronous reset assertion, popping every expectation due by then.
  initial begin : monitor
    exp_t e;
    while (!done) begin
      @(negedge clk or negedge rst_n);
      #1;
      while (q.size() > 0 && q[0].cyc <= cyc) begin
        e = q.pop_front();
        check(e);
      end
    end
    n_checks++;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL leftover: got %0d pending expectations, want 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: got no summary by time limit, want completion");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    tick();
    // Reset held with ena=1: position (0,0), pulses high.
    dir(1'b0, "reset_a", cyc + 1, 0, 0, 1'b1, 1'b1, !PIPE, 1'b1, 1'b1, 0);
    dir(1'b1, "reset_b", cyc + 1, 0, 0, 1'b1, 1'b1, !PIPE, 1'b1, 1'b1, 0);
    drive(1'b1, 1'b1);
    tick();
    drive(1'b1, 1'b1);
    tick();
    rst_n = 1'b1;

    // One line and a bit on dut_a, then on to pix_x=700 of line 1.
    while (t_a < 1500) begin
      drive(1'b1, 1'b0);
      case (t_a)
        1:    dir(1'b0, "first_edge",   cyc + 1, 1,   0, 1'b1,  1'b1, 1'b1,  1'b0, 1'b0, 0);
        639:  dir(1'b0, "last_visible", cyc + 1, 639, 0, 1'b1,  1'b1, 1'b1,  1'b0, 1'b0, 0);
        640:  dir(1'b0, "first_fp",     cyc + 1, 640, 0, 1'b1,  1'b1, PIPE,  1'b0, 1'b0, 0);
        656:  dir(1'b0, "hsync_fall",   cyc + 1, 656, 0, PIPE,  1'b1, 1'b0,  1'b0, 1'b0, 0);
        657:  dir(1'b0, "hsync_low",    cyc + 1, 657, 0, 1'b0,  1'b1, 1'b0,  1'b0, 1'b0, 0);
        752:  dir(1'b0, "hsync_rise",   cyc + 1, 752, 0, !PIPE, 1'b1, 1'b0,  1'b0, 1'b0, 0);
        799:  dir(1'b0, "line_end",     cyc + 1, 799, 0, 1'b1,  1'b1, 1'b0,  1'b0, 1'b0, 0);
        800:  dir(1'b0, "line_wrap",    cyc + 1, 0,   1, 1'b1,  1'b1, !PIPE, 1'b1, 1'b0, 0);
        1500: dir(1'b0, "x700_line1",   cyc + 1, 700, 1, 1'b0,  1'b1, 1'b0,  1'b0, 1'b0, 0);
        default: ;
      endcase
      tick();
    end

    // Asynchronous reset mid-line with hsync low.
    dir(1'b0, "async_rst_a", cyc, 0, 0, 1'b1, 1'b1, !PIPE, 1'b1, 1'b1, 0);
    dir(1'b1, "async_rst_b", cyc, 0, 0, 1'b1, 1'b1, !PIPE, 1'b0, 1'b0, 0);
    rst_n = 1'b0;
    t_a = 0;
    t_b = 0;
    tick();
    drive(1'b1, 1'b1);
    tick();
    drive(1'b1, 1'b1);
    tick();
    rst_n = 1'b1;

    // dut_b: run to the last visible pixel (7,3) and freeze for 5 cycles.
    while (t_b < 55) begin
      drive(1'b0, 1'b1);
      if (t_b == 55)
        dir(1'b1, "pre_freeze", cyc + 1, 7, 3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0);
      tick();
    end
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b0);
      dir(1'b1, "freeze", cyc + 1, 7, 3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0);
      tick();
    end
    drive(1'b0, 1'b1);
    dir(1'b1, "resume", cyc + 1, 8, 3, 1'b1, 1'b1, PIPE, 1'b0, 1'b0, 0);
    tick();

    // 256 frames of 128 cycles on dut_b: vsync window and frame wrap.
    while (t_b < 32768) begin
      drive(1'b0, 1'b1);
      case (t_b)
        80:    dir(1'b1, "vsync_fall",  cyc + 1, 0,  5, 1'b1, PIPE,  1'b0,  1'b1, 1'b0, 0);
        111:   dir(1'b1, "vsync_low",   cyc + 1, 15, 6, 1'b1, 1'b0,  1'b0,  1'b0, 1'b0, 0);
        112:   dir(1'b1, "vsync_rise",  cyc + 1, 0,  7, 1'b1, !PIPE, 1'b0,  1'b1, 1'b0, 0);
        127:   dir(1'b1, "frame0_end",  cyc + 1, 15, 7, 1'b1, 1'b1,  1'b0,  1'b0, 1'b0, 0);
        128:   dir(1'b1, "frame1",      cyc + 1, 0,  0, 1'b1, 1'b1,  !PIPE, 1'b1, 1'b1, 1);
        32767: dir(1'b1, "frame255",    cyc + 1, 15, 7, 1'b1, 1'b1,  1'b0,  1'b0, 1'b0, 255);
        32768: dir(1'b1, "frame_wrap",  cyc + 1, 0,  0, 1'b1, 1'b1,  !PIPE, 1'b1, 1'b1, 0);
        default: ;
      endcase
      tick();
    end
    tick();
    done = 1'b1;
  end

endmodule
